manchester_frame_tx: RTL and testbench



---
 rtl/amiga_trigger_pkg.sv | 38 +++
 rtl/lts_sync_fifo.sv | 65 ++++++
 rtl/manchester_frame_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_manchester_frame_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amiga_trigger_pkg.sv
// Shared constants for the AMIGA trigger line serializer.
//   - idle line/clock levels, Manchester half-bit polarity, default header
//   - framing FSM state encoding and small Manchester helper functions
// No ports: imported by manchester_frame_tx.
package amiga_trigger_pkg;

  // Idle levels of the line and forwarded clock between frames.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic CLK_IDLE  = 1'b1;

  // IEEE 802.3 convention: the first half carries the complement of the bit
  // while the forwarded clock is low, the second half carries the bit itself
  // while the forwarded clock is high.
  localparam logic MAN_FIRST_INV  = 1'b1;
  localparam logic MAN_CLK_FIRST  = 1'b0;
  localparam logic MAN_CLK_SECOND = 1'b1;

  // Default AMIGA frame header.
  localparam int                       AMIGA_HDR_LEN   = 5;
  localparam logic [AMIGA_HDR_LEN-1:0] AMIGA_HDR_VALUE = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  // Line level for one half of a Manchester bit.
  function automatic logic man_line(input logic b, input logic second_half);
    return second_half ? b : (b ^ MAN_FIRST_INV);
  endfunction

  // Forwarded clock level for one half of a Manchester bit.
  function automatic logic man_clk(input logic second_half);
    return second_half ? MAN_CLK_SECOND : MAN_CLK_FIRST;
  endfunction

endpackage

// File: rtl/lts_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
//   Latency: a pushed word is visible on o_pop_dat / o_empty the cycle after the push edge.
//   Backpressure: o_full is exported; pushes while full and pops while empty are ignored.
// Ports: clock, aresetn (sync, active-low, flushes contents),
//        i_push/i_push_dat write side, i_pop/o_pop_dat read side,
//        o_full, o_empty, o_level (occupancy, 0..2**AW).
module lts_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam int                DEPTH     = 2 ** AW;
  localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
  localparam logic [AW:0]       LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]       LVL_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the flushed pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_full    = (r_level == LVL_DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;

endmodule

// File: rtl/manchester_frame_tx.sv
// AMIGA trigger serializer: buffers words and sends each as a Manchester frame
//   (preamble, header, data MSB first, optional even parity) plus forwarded bit clock.
//   Latency: word accepted at edge t into an idle, empty block -> first half-bit on the line from edge t+2.
//   Backpressure: s_ready drops while the FIFO is full or reset is asserted.
// Ports: clock, aresetn (sync, active-low); s_valid/s_ready/s_data input stream;
//        tx_out line (idle 1), tx_clk forwarded clock (idle 1), busy (frame or gap),
//        frame_done (1-cycle pulse on the last cycle of a frame), fifo_level.
module manchester_frame_tx
  import amiga_trigger_pkg::*;
#(
  parameter int                 NBITS       = 16,
  parameter int                 DENOMINATOR = 12,
  parameter int                 HDR_LEN     = AMIGA_HDR_LEN,
  parameter logic [HDR_LEN-1:0] HDR_VALUE   = AMIGA_HDR_VALUE,
  parameter int                 PRE_LEN     = 0,
  parameter logic               PRE_BIT     = 1'b0,
  parameter int                 PARITY_EN   = 0,
  parameter int                 GAP_BITS    = 1,
  parameter int                 FIFO_AW     = 2
) (
  input  logic               clock,
  input  logic               aresetn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [NBITS-1:0]   s_data,
  output logic               tx_out,
  output logic               tx_clk,
  output logic               busy,
  output logic               frame_done,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int HALF      = DENOMINATOR / 2;
  localparam int PAR_BITS  = (PARITY_EN != 0) ? 1 : 0;
  localparam int FRAME_LEN = PRE_LEN + HDR_LEN + NBITS + PAR_BITS;
  localparam int GAP_CYC   = GAP_BITS * DENOMINATOR;

  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W  = $clog2(FRAME_LEN + 1);
  localparam int GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  if ((DENOMINATOR < 2) || ((DENOMINATOR % 2) != 0)) begin : g_bad_denominator
    $error("manchester_frame_tx: DENOMINATOR must be even and >= 2");
  end
  if (HDR_LEN < 1) begin : g_bad_hdr_len
    $error("manchester_frame_tx: HDR_LEN must be >= 1");
  end

  // FIFO
  logic               w_push;
  logic               w_pop;
  logic [NBITS-1:0]   w_head;
  logic               w_full;
  logic               w_empty;
  logic [FIFO_AW:0]   w_level;

  assign s_ready = aresetn && !w_full;
  assign w_push  = s_valid && s_ready;

  lts_sync_fifo #(
    .WIDTH (NBITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock      (clock),
    .aresetn    (aresetn),
    .i_push     (w_push),
    .i_push_dat (s_data),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  assign fifo_level = w_level;

  // Frame image built from the FIFO head: shifted in MSB first, so the bit on
  // the line is always the top bit of the shift register.
  logic [FRAME_LEN-1:0] w_frame_load;
  logic [HDR_LEN-1:0]   w_hdr_tmp;
  logic [NBITS-1:0]     w_dat_tmp;

  always_comb begin
    w_frame_load = '0;
    w_hdr_tmp    = HDR_VALUE;
    w_dat_tmp    = w_head;
    for (int i = 0; i < PRE_LEN; i++) begin
      w_frame_load = {w_frame_load[FRAME_LEN-2:0], PRE_BIT};
    end
    for (int i = 0; i < HDR_LEN; i++) begin
      w_frame_load = {w_frame_load[FRAME_LEN-2:0], w_hdr_tmp[HDR_LEN-1]};
      w_hdr_tmp    = w_hdr_tmp << 1;
    end
    for (int i = 0; i < NBITS; i++) begin
      w_frame_load = {w_frame_load[FRAME_LEN-2:0], w_dat_tmp[NBITS-1]};
      w_dat_tmp    = w_dat_tmp << 1;
    end
    if (PARITY_EN != 0) begin
      // Even parity: the data plus this bit hold an even number of ones.
      w_frame_load = {w_frame_load[FRAME_LEN-2:0], ^w_head};
    end
  end

  // Framing FSM state and registered outputs
  tx_state_t            r_state;
  logic [HALF_W-1:0]    r_half_cnt;
  logic                 r_phase;      // 0: first half, 1: second half
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_tx_out;
  logic                 r_tx_clk;
  logic                 r_busy;
  logic                 r_frame_done;

  tx_state_t            w_state_nxt;
  logic [HALF_W-1:0]    w_half_nxt;
  logic                 w_phase_nxt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [GAP_W-1:0]     w_gap_nxt;
  logic [FRAME_LEN-1:0] w_shift_nxt;
  logic                 w_tx_out_nxt;
  logic                 w_tx_clk_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  // Outputs are registered from the current state, so the line lags the
  // state by one cycle: the pop edge is followed one edge later by the first
  // half-bit, and the final half-bit cycle carries the frame_done pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_half_nxt   = r_half_cnt;
    w_phase_nxt  = r_phase;
    w_bit_nxt    = r_bit_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_shift_nxt  = r_shift;
    w_pop        = 1'b0;
    w_tx_out_nxt = LINE_IDLE;
    w_tx_clk_nxt = CLK_IDLE;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_frame_load;
          w_half_nxt  = '0;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = '0;
          w_gap_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end

      ST_SEND: begin
        w_busy_nxt   = 1'b1;
        w_tx_out_nxt = man_line(r_shift[FRAME_LEN-1], r_phase);
        w_tx_clk_nxt = man_clk(r_phase);
        if (r_half_cnt == HALF_LAST) begin
          w_half_nxt  = '0;
          w_phase_nxt = ~r_phase;
          if (r_phase) begin
            if (r_bit_cnt == BIT_LAST) begin
              w_done_nxt  = 1'b1;
              w_gap_nxt   = '0;
              w_state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            end else begin
              w_bit_nxt   = r_bit_cnt + BIT_ONE;
              w_shift_nxt = r_shift << 1;
            end
          end
        end else begin
          w_half_nxt = r_half_cnt + HALF_ONE;
        end
      end

      ST_GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_half_cnt   <= '0;
      r_phase      <= 1'b0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_shift      <= '0;
      r_tx_out     <= LINE_IDLE;
      r_tx_clk     <= CLK_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_half_cnt   <= w_half_nxt;
      r_phase      <= w_phase_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_shift      <= w_shift_nxt;
      r_tx_out     <= w_tx_out_nxt;
      r_tx_clk     <= w_tx_clk_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign tx_out     = r_tx_out;
  assign tx_clk     = r_tx_clk;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Bench for manchester_frame_tx: three instances (defaults; parity+preamble;
// DENOMINATOR=4 with no gap) driven by directed vectors and hand sequences.
module tb_manchester_frame_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        aresetn;
  logic [2:0]  sv;
  logic [15:0] sd [3];
  logic [2:0]  ready_v, tx_out_v, tx_clk_v, busy_v, done_v;
  logic [2:0]  level_v [3];

  manchester_frame_tx u_def (
    .clock(clock), .aresetn(aresetn), .s_valid(sv[0]), .s_ready(ready_v[0]),
    .s_data(sd[0]), .tx_out(tx_out_v[0]), .tx_clk(tx_clk_v[0]), .busy(busy_v[0]),
    .frame_done(done_v[0]), .fifo_level(level_v[0])
  );

  manchester_frame_tx #(.PARITY_EN(1), .PRE_LEN(2), .PRE_BIT(1'b0)) u_par (
    .clock(clock), .aresetn(aresetn), .s_valid(sv[1]), .s_ready(ready_v[1]),
    .s_data(sd[1]), .tx_out(tx_out_v[1]), .tx_clk(tx_clk_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1]), .fifo_level(level_v[1])
  );

  manchester_frame_tx #(.DENOMINATOR(4), .GAP_BITS(0)) u_fast (
    .clock(clock), .aresetn(aresetn), .s_valid(sv[2]), .s_ready(ready_v[2]),
    .s_data(sd[2]), .tx_out(tx_out_v[2]), .tx_clk(tx_clk_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2]), .fifo_level(level_v[2])
  );

  // Cycle stamp and per-instance activity counters (outputs of the cycle
  // that ends at each rising edge).
  int cyc = 0;
  int busy_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i] === 1'b1) busy_cnt[i] <= busy_cnt[i] + 1;
      if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  // Selected instance for the capture helpers.
  int         sel = 0;
  logic       cur_tx_out, cur_tx_clk, cur_busy, cur_done;
  logic [2:0] cur_level;
  always_comb begin
    cur_tx_out = tx_out_v[sel];
    cur_tx_clk = tx_clk_v[sel];
    cur_busy   = busy_v[sel];
    cur_done   = done_v[sel];
    cur_level  = level_v[sel];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_one(input int which, input logic [15:0] d, output int t_acc);
    @(negedge clock);
    check($sformatf("push_ready_%0d", which), ready_v[which], 1);
    sv[which] = 1'b1;
    sd[which] = d;
    @(negedge clock);
    sv[which] = 1'b0;
    t_acc = cyc;
  endtask

  // Waits for the next first half-bit, then samples every cycle of the frame:
  // checks clock/line per half, busy, and that frame_done is high only on the
  // very last cycle. Decoded bits are the second-half line values.
  task automatic capture(input int den, input int flen, output logic [31:0] bits,
                         output int enc, output int ts, output int te, output bit to);
    int   n;
    logic a;
    bit   last;
    bits = '0; enc = 0; ts = 0; te = 0; to = 1'b0; n = 0; a = 1'b0;
    do begin
      @(negedge clock);
      n++;
    end while (cur_tx_clk !== 1'b0 && n < 3000);
    if (cur_tx_clk !== 1'b0) begin
      to = 1'b1;
      return;
    end
    ts = cyc;
    for (int b = 0; b < flen; b++) begin
      for (int h = 0; h < den; h++) begin
        if (b != 0 || h != 0) @(negedge clock);
        last = (b == flen - 1) && (h == den - 1);
        if (cur_busy !== 1'b1) enc++;
        if (cur_done !== last) enc++;
        if (h < den / 2) begin
          if (h == 0) a = cur_tx_out;
          if (cur_tx_clk !== 1'b0 || cur_tx_out !== a) enc++;
        end else begin
          if (cur_tx_clk !== 1'b1 || cur_tx_out !== ~a) enc++;
        end
      end
      bits = {bits[30:0], cur_tx_out};
    end
    te = cyc;
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((cur_busy !== 1'b0 || cur_level !== 3'd0) && n < 2000);
    to = (cur_busy !== 1'b0 || cur_level !== 3'd0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [20:0] exp_bits;
    int          exp_busy;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] bp_words [8];
  logic [31:0] bp_bits [5];
  int          bp_enc [5], bp_ts [5], bp_te [5];
  bit          bp_to [5];
  int          bp_acc;

  logic [31:0] bits, bits2;
  int          enc, enc2, ts, te, ts2, te2, t_acc, b0, d0;
  bit          to, to2;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'hA5C3, 21'b11000_1010010111000011, 264};
    vecs[1] = '{16'h0000, 21'b11000_0000000000000000, 264};
    vecs[2] = '{16'hFFFF, 21'b11000_1111111111111111, 264};
    vecs[3] = '{16'h8001, 21'b11000_1000000000000001, 264};
    vecs[4] = '{16'h1234, 21'b11000_0001001000110100, 264};
    bp_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 16'h5555, 16'h6666, 16'h7777, 16'h8888};

    aresetn = 1'b0;
    sv      = '0;
    sd[0] = '0; sd[1] = '0; sd[2] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx_out", tx_out_v, 3'b111);
    check("rst_tx_clk", tx_clk_v, 3'b111);
    check("rst_busy", busy_v, 3'b000);
    check("rst_frame_done", done_v, 3'b000);
    check("rst_s_ready", ready_v, 3'b000);
    for (int i = 0; i < 3; i++) check($sformatf("rst_level_%0d", i), level_v[i], 0);
    aresetn = 1'b1;
    @(negedge clock);
    check("ready_after_rst", ready_v, 3'b111);

    // Table-driven single frames on the default instance
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      b0 = busy_cnt[0];
      d0 = done_cnt[0];
      push_one(0, vecs[i].data, t_acc);
      capture(12, 21, bits, enc, ts, te, to);
      check($sformatf("vec%0d_timeout", i), to, 0);
      check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
      check($sformatf("vec%0d_encoding", i), enc, 0);
      check($sformatf("vec%0d_latency", i), ts - t_acc, 2);
      wait_idle(to);
      check($sformatf("vec%0d_idle_timeout", i), to, 0);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt[0] - b0, vecs[i].exp_busy);
      check($sformatf("vec%0d_done_pulses", i), done_cnt[0] - d0, 1);
    end

    // Backpressure: hold s_valid from empty until s_ready falls
    fork
      begin
        bp_acc = 0;
        sv[0] = 1'b1;
        sd[0] = bp_words[0];
        for (int n = 0; n < 20; n++) begin
          if (ready_v[0] !== 1'b1) break;
          bp_acc++;
          @(negedge clock);
          sd[0] = bp_words[bp_acc % 8];
        end
        sv[0] = 1'b0;
        check("bp_full_level", level_v[0], 4);
      end
      begin
        for (int k = 0; k < 5; k++)
          capture(12, 21, bp_bits[k], bp_enc[k], bp_ts[k], bp_te[k], bp_to[k]);
      end
    join
    check("bp_accepted", bp_acc, 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_timeout", k), bp_to[k], 0);
      check($sformatf("bp%0d_bits", k), bp_bits[k], {5'b11000, bp_words[k]});
      check($sformatf("bp%0d_encoding", k), bp_enc[k], 0);
      if (k > 0) check($sformatf("bp%0d_gap", k), bp_ts[k] - bp_te[k-1], 14);
    end
    wait_idle(to);
    check("bp_idle_timeout", to, 0);

    // Parity and preamble instance
    sel = 1;
    b0 = busy_cnt[1];
    push_one(1, 16'h0001, t_acc);
    capture(12, 24, bits, enc, ts, te, to);
    check("par1_timeout", to, 0);
    check("par1_bits", bits, 24'b00_11000_0000000000000001_1);
    check("par1_encoding", enc, 0);
    check("par1_latency", ts - t_acc, 2);
    wait_idle(to);
    check("par1_busy_cycles", busy_cnt[1] - b0, 300);
    push_one(1, 16'h0003, t_acc);
    capture(12, 24, bits, enc, ts, te, to);
    check("par3_bits", bits, 24'b00_11000_0000000000000011_0);
    check("par3_encoding", enc, 0);
    wait_idle(to);

    // DENOMINATOR=4, no gap: all-zeros then all-ones, second push lands on the pop edge
    sel = 2;
    d0 = done_cnt[2];
    @(negedge clock);
    sv[2] = 1'b1;
    sd[2] = 16'h0000;
    @(negedge clock);
    t_acc = cyc;
    check("fast_level_after_push", level_v[2], 1);
    sd[2] = 16'hFFFF;
    @(negedge clock);
    sv[2] = 1'b0;
    check("simul_push_pop_level", level_v[2], 1);
    capture(4, 21, bits, enc, ts, te, to);
    capture(4, 21, bits2, enc2, ts2, te2, to2);
    check("fast0_timeout", to, 0);
    check("fast0_bits", bits, 21'b11000_0000000000000000);
    check("fast0_encoding", enc, 0);
    check("fast0_latency", ts - t_acc, 2);
    check("fast1_timeout", to2, 0);
    check("fast1_bits", bits2, 21'b11000_1111111111111111);
    check("fast1_encoding", enc2, 0);
    check("fast_back_to_back_gap", ts2 - te, 2);
    wait_idle(to);
    repeat (20) @(negedge clock);
    check("fast_done_pulses", done_cnt[2] - d0, 2);
    check("fast_final_level", level_v[2], 0);

    // Reset mid-frame
    sel = 0;
    d0 = done_cnt[0];
    @(negedge clock);
    sv[0] = 1'b1;
    sd[0] = 16'hDEAD;
    @(negedge clock);
    sd[0] = 16'hBEEF;
    @(negedge clock);
    sd[0] = 16'hCAFE;
    @(negedge clock);
    sv[0] = 1'b0;
    repeat (96) @(negedge clock);
    check("pre_rst_busy", busy_v[0], 1);
    aresetn = 1'b0;
    @(negedge clock);
    check("midrst_tx_out", tx_out_v[0], 1);
    check("midrst_tx_clk", tx_clk_v[0], 1);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_level", level_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_s_ready", ready_v[0], 0);
    aresetn = 1'b1;
    b0 = busy_cnt[0];
    repeat (300) @(negedge clock);
    check("post_rst_busy_cycles", busy_cnt[0] - b0, 0);
    check("post_rst_no_done", done_cnt[0] - d0, 0);
    check("post_rst_level", level_v[0], 0);
    push_one(0, 16'h5A5A, t_acc);
    capture(12, 21, bits, enc, ts, te, to);
    check("post_rst_timeout", to, 0);
    check("post_rst_bits", bits, 21'b11000_0101101001011010);
    check("post_rst_encoding", enc, 0);
    check("post_rst_latency", ts - t_acc, 2);
    wait_idle(to);
    check("post_rst_done", done_cnt[0] - d0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
